// File: rtl/bt656_timing_decoder.sv
// BT.656 TRS detector and timing recovery: H/V/F flags, sample/line counters and lock status.
// The stream leaves 4 clocks late and every timing output is registered against that delayed word.
module bt656_timing_decoder #(
  parameter int LINE_SIZE  = 1716,
  parameter int LINE_COUNT = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  bt656_stream_in,
  output logic [9:0]  bt656_stream_out,
  output logic        trs_start,
  output logic        eav,
  output logic        sav,
  output logic        H,
  output logic        V,
  output logic        F,
  output logic [10:0] sample_cnt,
  output logic [9:0]  line_cnt,
  output logic        frame_start,
  output logic        locked,
  output logic        frame_ok,
  output logic        trs_error
);

  localparam logic [10:0] LAST_SAMPLE = 11'(LINE_SIZE - 1);
  localparam logic [9:0]  LAST_LINE   = 10'(LINE_COUNT - 1);
  localparam logic [10:0] SAMPLE_MAX  = 11'h7FF;
  localparam logic [9:0]  LINE_MAX    = 10'h3FF;

  // Only the upper 8 bits take part, so 8-bit sources padded with zeros decode identically.
  function automatic logic trs_prefix(input logic [7:0] w0, input logic [7:0] w1,
                                      input logic [7:0] w2);
    return (w0 == 8'hFF) && (w1 == 8'h00) && (w2 == 8'h00);
  endfunction

  function automatic logic xyz_ok(input logic [7:0] x);
    return x[7] && (x[3] == (x[5] ^ x[4])) && (x[2] == (x[6] ^ x[4]))
        && (x[1] == (x[6] ^ x[5])) && (x[0] == (x[6] ^ x[5] ^ x[4]));
  endfunction

  logic [9:0]  d1_q, d2_q, d3_q, d4_q;
  logic [7:0]  d5_q, d6_q;
  logic        trs_start_q, eav_q, sav_q, h_q, v_q, f_q;
  logic        frame_start_q, locked_q, frame_ok_q, trs_error_q, eav_seen_q;
  logic [10:0] sample_cnt_q;
  logic [9:0]  line_cnt_q;

  logic        trs_start_d, eav_d, sav_d, h_d, v_d, f_d;
  logic        frame_start_d, locked_d, frame_ok_d, trs_error_d, eav_seen_d;
  logic [10:0] sample_cnt_d;
  logic [9:0]  line_cnt_d;
  logic        look_hit_s, cur_match_s, cur_valid_s, cur_eav_s;

  // TRS windows: look-ahead (3FF about to reach the output) and current (XYZ about to reach it).
  always_comb begin
    look_hit_s  = trs_prefix(d3_q[9:2], d2_q[9:2], d1_q[9:2]) && xyz_ok(bt656_stream_in[9:2]);
    cur_match_s = trs_prefix(d6_q, d5_q, d4_q[9:2]);
    cur_valid_s = cur_match_s && xyz_ok(d3_q[9:2]);
    cur_eav_s   = cur_valid_s && d3_q[6];
  end

  // Next-state for flags, counters, lock and the single-cycle event pulses.
  always_comb begin
    trs_start_d   = look_hit_s;
    eav_d         = 1'b0;
    sav_d         = 1'b0;
    frame_start_d = 1'b0;
    trs_error_d   = 1'b0;
    h_d           = h_q;
    v_d           = v_q;
    f_d           = f_q;
    line_cnt_d    = line_cnt_q;
    frame_ok_d    = frame_ok_q;
    eav_seen_d    = eav_seen_q;

    if (eav_q) begin
      sample_cnt_d = 11'd0;
    end else if (eav_seen_q && (sample_cnt_q != SAMPLE_MAX)) begin
      sample_cnt_d = sample_cnt_q + 11'd1;
    end else begin
      sample_cnt_d = sample_cnt_q;
    end

    if (sample_cnt_d == SAMPLE_MAX) begin
      locked_d = 1'b0;
    end else begin
      locked_d = locked_q;
    end

    if (cur_valid_s) begin
      h_d   = d3_q[6];
      v_d   = d3_q[7];
      f_d   = d3_q[8];
      eav_d = d3_q[6];
      sav_d = ~d3_q[6];
    end else if (cur_match_s) begin
      trs_error_d = 1'b1;
      locked_d    = 1'b0;
    end else begin
      trs_error_d = 1'b0;
    end

    // sample_cnt_d is the count aligned with the EAV XYZ word itself.
    if (cur_eav_s) begin
      eav_seen_d = 1'b1;
      locked_d   = eav_seen_q && (sample_cnt_d == LAST_SAMPLE);
      if (f_q && !d3_q[8]) begin
        frame_start_d = 1'b1;
        frame_ok_d    = (line_cnt_q == LAST_LINE);
        line_cnt_d    = 10'd0;
      end else if (line_cnt_q != LINE_MAX) begin
        line_cnt_d = line_cnt_q + 10'd1;
      end else begin
        line_cnt_d = line_cnt_q;
      end
    end else begin
      eav_seen_d = eav_seen_q;
    end
  end

  // Delay line and all registered timing state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1_q          <= 10'd0;
      d2_q          <= 10'd0;
      d3_q          <= 10'd0;
      d4_q          <= 10'd0;
      d5_q          <= 8'd0;
      d6_q          <= 8'd0;
      trs_start_q   <= 1'b0;
      eav_q         <= 1'b0;
      sav_q         <= 1'b0;
      h_q           <= 1'b0;
      v_q           <= 1'b0;
      f_q           <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      frame_ok_q    <= 1'b0;
      trs_error_q   <= 1'b0;
      eav_seen_q    <= 1'b0;
      sample_cnt_q  <= 11'd0;
      line_cnt_q    <= 10'd0;
    end else begin
      d1_q          <= bt656_stream_in;
      d2_q          <= d1_q;
      d3_q          <= d2_q;
      d4_q          <= d3_q;
      d5_q          <= d4_q[9:2];
      d6_q          <= d5_q;
      trs_start_q   <= trs_start_d;
      eav_q         <= eav_d;
      sav_q         <= sav_d;
      h_q           <= h_d;
      v_q           <= v_d;
      f_q           <= f_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      frame_ok_q    <= frame_ok_d;
      trs_error_q   <= trs_error_d;
      eav_seen_q    <= eav_seen_d;
      sample_cnt_q  <= sample_cnt_d;
      line_cnt_q    <= line_cnt_d;
    end
  end

  assign bt656_stream_out = d4_q;
  assign trs_start        = trs_start_q;
  assign eav              = eav_q;
  assign sav              = sav_q;
  assign H                = h_q;
  assign V                = v_q;
  assign F                = f_q;
  assign sample_cnt       = sample_cnt_q;
  assign line_cnt         = line_cnt_q;
  assign frame_start      = frame_start_q;
  assign locked           = locked_q;
  assign frame_ok         = frame_ok_q;
  assign trs_error        = trs_error_q;

endmodule

// File: tb/tb_bt656_timing_decoder.sv
// Randomized bench for bt656_timing_decoder: scaled-down frames compared every cycle against
// a word-index reference model of the timing rules.
module tb_bt656_timing_decoder;

  localparam int LS      = 100;
  localparam int LC      = 10;
  localparam int SAV_POS = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  din;
  logic [9:0]  dout;
  logic        trs_start, eav, sav, H, V, F;
  logic [10:0] sample_cnt;
  logic [9:0]  line_cnt;
  logic        frame_start, locked, frame_ok, trs_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: history of delivered words and the event-level timing state.
  logic [9:0] hist[$];
  int p, e_prev, m_line, e_smp;
  bit seen, m_h, m_v, m_f, m_lock, m_fok;
  bit e_trs, e_eav, e_sav, e_fs, e_err;

  always #5 clk = ~clk;

  bt656_timing_decoder #(.LINE_SIZE(LS), .LINE_COUNT(LC)) dut (
    .clk(clk), .reset(reset), .bt656_stream_in(din), .bt656_stream_out(dout),
    .trs_start(trs_start), .eav(eav), .sav(sav), .H(H), .V(V), .F(F),
    .sample_cnt(sample_cnt), .line_cnt(line_cnt), .frame_start(frame_start),
    .locked(locked), .frame_ok(frame_ok), .trs_error(trs_error)
  );

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [9:0] make_xyz(input bit f, input bit v, input bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
  endfunction

  function automatic bit xyz_valid(input logic [9:0] w);
    logic [9:0] ref_w;
    ref_w = make_xyz(w[8], w[7], w[6]);
    return w[9:2] == ref_w[9:2];
  endfunction

  function automatic bit is_prefix(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    return (a[9:2] == 8'hFF) && (b[9:2] == 8'h00) && (c[9:2] == 8'h00);
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (4) hist.push_back(10'd0);
    p = 0; e_prev = 0; m_line = 0; seen = 0;
    m_h = 0; m_v = 0; m_f = 0; m_lock = 0; m_fok = 0;
  endtask

  // Expected outputs while the delayed stream shows word hist[p].
  task automatic model_step();
    logic [9:0] w;
    bit pre, val;
    int gap;
    w = hist[p];
    e_eav = 0; e_sav = 0; e_fs = 0; e_err = 0;
    pre = (p >= 3) && is_prefix(hist[p-3], hist[p-2], hist[p-1]);
    val = pre && xyz_valid(w);
    gap = p - e_prev - 1;
    e_smp = !seen ? 0 : (gap > 2047 ? 2047 : gap);
    if (val && w[6]) begin
      e_eav = 1;
      m_lock = seen && (e_smp == LS - 1);
      if (m_f && !w[8]) begin
        e_fs = 1; m_fok = (m_line == LC - 1); m_line = 0;
      end else if (m_line < 1023) begin
        m_line++;
      end
      seen = 1; e_prev = p;
    end else if (pre && !val) begin
      e_err = 1; m_lock = 0;
    end else if (e_smp == 2047) begin
      m_lock = 0;
    end
    if (val) begin
      m_h = w[6]; m_v = w[7]; m_f = w[8]; e_sav = !w[6];
    end
    e_trs = is_prefix(hist[p], hist[p+1], hist[p+2]) && xyz_valid(hist[p+3]);
  endtask

  task automatic compare_all();
    check_eq("stream", dout, hist[p]);
    check_eq("trs_start", trs_start, e_trs);
    check_eq("eav", eav, e_eav);
    check_eq("sav", sav, e_sav);
    check_eq("H", H, m_h);
    check_eq("V", V, m_v);
    check_eq("F", F, m_f);
    check_eq("sample_cnt", sample_cnt, e_smp);
    check_eq("line_cnt", line_cnt, m_line);
    check_eq("frame_start", frame_start, e_fs);
    check_eq("locked", locked, m_lock);
    check_eq("frame_ok", frame_ok, m_fok);
    check_eq("trs_error", trs_error, e_err);
  endtask

  task automatic check_all_zero();
    check_eq("rst_stream", dout, 0);
    check_eq("rst_pulses", {trs_start, eav, sav, frame_start, trs_error}, 0);
    check_eq("rst_flags", {H, V, F}, 0);
    check_eq("rst_sample_cnt", sample_cnt, 0);
    check_eq("rst_line_cnt", line_cnt, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_frame_ok", frame_ok, 0);
  endtask

  task automatic tick(input logic [9:0] w);
    din = w;
    @(posedge clk);
    #1;
    hist.push_back(w);
    p++;
    model_step();
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_all_zero();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One line: EAV at word 0, horizontal blanking, SAV, then random active video.
  task automatic send_line(input int l, input int len, input bit corrupt, input int stop_at);
    bit f, v, pad;
    logic [9:0] ff, w;
    f   = (l >= LC / 2);
    v   = (l < 2) || ((l >= LC / 2) && (l < LC / 2 + 2));
    pad = bit'($urandom_range(0, 1));
    ff  = pad ? 10'h3FC : 10'h3FF;
    for (int i = 0; i < len && i < stop_at; i++) begin
      if (i == 0 || i == SAV_POS) w = ff;
      else if (i == 1 || i == 2 || i == SAV_POS + 1 || i == SAV_POS + 2) w = 10'h000;
      else if (i == 3) begin
        w = make_xyz(f, v, 1'b1);
        if (corrupt) w ^= 10'h008;
      end
      else if (i == SAV_POS + 3) w = make_xyz(f, v, 1'b0);
      else if (i < SAV_POS) w = (i % 2 == 1) ? 10'h040 : 10'h200;
      else w = 10'($urandom_range(4, 1019));
      tick(w);
    end
  endtask

  task automatic send_frame(input int bad_line, input int short_line, input int first_line);
    for (int l = first_line; l < LC; l++)
      send_line(l, (l == short_line) ? LS - 16 : LS, l == bad_line, LS);
  endtask

  initial begin
    reset = 1'b1;
    din   = 10'd0;
    model_reset();
    #2;
    check_all_zero();
    @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (3) send_frame(-1, -1, 0);
    send_frame(5, -1, 0);
    send_frame(-1, 3, 0);
    repeat (2) send_frame(-1, -1, 0);
    repeat (3000) tick(10'h200);
    send_frame(-1, -1, 0);
    send_line(0, LS, 1'b0, LS);
    send_line(1, LS, 1'b0, 50);
    do_reset();
    send_frame(-1, -1, 2);
    repeat (2) send_frame(-1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
